// File: rtl/display_scheduler.sv
// Time-shares a three-digit seven-segment display between two 7-bit sources,
// converting the selected value to BCD with a sequential double-dabble engine.
module display_scheduler #(
    parameter int unsigned CLKS_PER_SLOT = 50_000_000,
    parameter bit          BLANK_LEADING = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] val_a,
    input  logic       en_a,
    input  logic [6:0] val_b,
    input  logic       en_b,
    input  logic       freeze,
    output logic [6:0] d0,
    output logic [6:0] d1,
    output logic [6:0] d2,
    output logic       sel,
    output logic       busy
);

    localparam int unsigned VW = 7;
    localparam int unsigned BW = 12;
    localparam int unsigned SW = 7;
    localparam int unsigned IW = 3;
    localparam int unsigned CW = (CLKS_PER_SLOT > 1) ? $clog2(CLKS_PER_SLOT) : 1;
    localparam logic [SW-1:0] SEG_BLANK = 7'b1111111;

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, COMMIT} state_t;

    state_t          state;
    state_t          state_nxt;
    logic            cur;
    logic [VW-1:0]   cmp;
    logic [VW-1:0]   bin;
    logic [BW-1:0]   bcd;
    logic [IW-1:0]   iter;
    logic [CW-1:0]   slot_cnt;
    logic            slot_flag;
    logic            shown;

    logic            any_en;
    logic            both_en;
    logic            pick_sel;
    logic [VW-1:0]   pick_val;
    logic            trigger;
    logic            start;
    logic            blank_now;
    logic            consume;
    logic            slot_tc;
    logic [BW-1:0]   bcd_adj;
    logic [BW-1:0]   bcd_nxt;
    logic [VW-1:0]   bin_nxt;
    logic [SW-1:0]   d0_c;
    logic [SW-1:0]   d1_c;
    logic [SW-1:0]   d2_c;

    function automatic logic [SW-1:0] seg7(input logic [3:0] n);
        case (n)
            4'd0:    return 7'b1000000;
            4'd1:    return 7'b1111001;
            4'd2:    return 7'b0100100;
            4'd3:    return 7'b0110000;
            4'd4:    return 7'b0011001;
            4'd5:    return 7'b0010010;
            4'd6:    return 7'b0000010;
            4'd7:    return 7'b1111000;
            4'd8:    return 7'b0000000;
            4'd9:    return 7'b0010000;
            default: return SEG_BLANK;
        endcase
    endfunction

    function automatic logic [3:0] adj3(input logic [3:0] n);
        return (n >= 4'd5) ? n + 4'd3 : n;
    endfunction

    // Source selection and conversion trigger, evaluated in IDLE
    always_comb begin
        any_en   = en_a | en_b;
        both_en  = en_a & en_b;
        if (en_a && !en_b)
            pick_sel = 1'b0;
        else if (en_b && !en_a)
            pick_sel = 1'b1;
        else
            pick_sel = slot_flag ? ~sel : sel;
        pick_val = pick_sel ? val_b : val_a;
        trigger  = any_en & ((pick_sel != sel) | (pick_val != cmp) | ~shown);
        slot_tc  = both_en & ~freeze & (slot_cnt == CW'(CLKS_PER_SLOT - 1));
    end

    // One double-dabble step and the segment encoding of the finished result
    always_comb begin
        bcd_adj = {adj3(bcd[11:8]), adj3(bcd[7:4]), adj3(bcd[3:0])};
        {bcd_nxt, bin_nxt} = {bcd_adj, bin} << 1;
        d0_c = seg7(bcd[3:0]);
        d1_c = (BLANK_LEADING && bcd[11:8] == 4'd0 && bcd[7:4] == 4'd0) ? SEG_BLANK : seg7(bcd[7:4]);
        d2_c = (BLANK_LEADING && bcd[11:8] == 4'd0) ? SEG_BLANK : seg7(bcd[11:8]);
    end

    always_ff @(posedge clk) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        start     = 1'b0;
        blank_now = 1'b0;
        consume   = 1'b0;
        case (state)
            IDLE: begin
                if (!freeze) begin
                    consume = 1'b1;
                    if (!any_en) begin
                        blank_now = 1'b1;
                    end else if (trigger) begin
                        start     = 1'b1;
                        state_nxt = LOAD;
                    end
                end
            end
            LOAD:    state_nxt = SHIFT;
            SHIFT:   if (iter == IW'(VW - 1)) state_nxt = COMMIT;
            COMMIT:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Slot timer; a boundary stays latched until an IDLE cycle consumes it
    always_ff @(posedge clk) begin
        if (reset) begin
            slot_cnt  <= '0;
            slot_flag <= 1'b0;
        end else begin
            if (both_en && !freeze)
                slot_cnt <= slot_tc ? '0 : slot_cnt + CW'(1);
            else
                slot_cnt <= '0;
            if (consume)
                slot_flag <= 1'b0;
            if (slot_tc)
                slot_flag <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cur   <= 1'b0;
            cmp   <= '0;
            bin   <= '0;
            bcd   <= '0;
            iter  <= '0;
            shown <= 1'b0;
            busy  <= 1'b0;
            sel   <= 1'b0;
            d0    <= SEG_BLANK;
            d1    <= SEG_BLANK;
            d2    <= SEG_BLANK;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        cur  <= pick_sel;
                        busy <= 1'b1;
                    end
                    if (blank_now) begin
                        d0    <= SEG_BLANK;
                        d1    <= SEG_BLANK;
                        d2    <= SEG_BLANK;
                        shown <= 1'b0;
                    end
                end
                LOAD: begin
                    bin  <= cur ? val_b : val_a;
                    cmp  <= cur ? val_b : val_a;
                    bcd  <= '0;
                    iter <= '0;
                end
                SHIFT: begin
                    bcd  <= bcd_nxt;
                    bin  <= bin_nxt;
                    iter <= iter + IW'(1);
                    if (state_nxt == COMMIT)
                        busy <= 1'b0;
                end
                COMMIT: begin
                    d0    <= d0_c;
                    d1    <= d1_c;
                    d2    <= d2_c;
                    sel   <= cur;
                    shown <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
